// File: rtl/rst_sequencer_pkg.sv
// rst_sequencer_pkg: shared states, constants and width helper for the reset sequencer
package rst_sequencer_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      SW_ASSERT = 2'd3
   } state_t;

   localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

   function automatic int cnt_w(input int term);
      return (term > 1) ? $clog2(term) : 1;
   endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock status, software reset handshake and sequenced reset outputs
interface rst_sequencer_if #(
   parameter int NUM_DOMAINS = 4
);

   logic                   locked_i;
   logic                   sw_rst_req_i;
   logic                   sw_rst_ack_o;
   logic [NUM_DOMAINS-1:0] rst_n_o;
   logic                   seq_busy_o;
   logic                   all_released_o;
   logic [7:0]             lock_loss_cnt_o;

   modport slave (
      input  locked_i, sw_rst_req_i,
      output sw_rst_ack_o, rst_n_o, seq_busy_o, all_released_o, lock_loss_cnt_o
   );

   modport master (
      output locked_i, sw_rst_req_i,
      input  sw_rst_ack_o, rst_n_o, seq_busy_o, all_released_o, lock_loss_cnt_o
   );

endinterface

// File: rtl/rst_sequencer_counter.sv
// rst_sequencer_counter: up-counter that flags its TERM-th enabled edge and restarts
module rst_sequencer_counter
   import rst_sequencer_pkg::*;
#(
   parameter int TERM = 8
) (
   input  logic wb_clk_i,
   input  logic wb_rst_n_i,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = cnt_w(TERM);

   logic [W-1:0] cnt;

   assign tc = en && (cnt == W'(TERM - 1));

   // count enabled edges, restart on terminal count or clear
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i || clr)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: qualifies PLL lock, releases reset domains in staggered order, handles sw reset
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int STAGE_DELAY = 16,
   parameter int LOCK_FILTER = 8,
   parameter int SWRST_PULSE = 32
) (
   input logic            wb_clk_i,
   input logic            wb_rst_n_i,
   rst_sequencer_if.slave bus
);

   localparam int IW = cnt_w(NUM_DOMAINS);

   state_t                 state, state_d;
   logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
   logic [IW-1:0]          idx, idx_d;
   logic                   pending, pending_d;
   logic                   ack, ack_d;
   logic [7:0]             loss_cnt, loss_d;
   logic                   busy_q, all_q;
   logic                   filt_en, dly_en, sw_en;
   logic                   filt_tc, dly_tc, sw_tc;
   logic                   lock_loss, accept;

   assign lock_loss = !bus.locked_i && (state != WAIT_LOCK);
   assign accept    = bus.sw_rst_req_i && !ack;
   assign filt_en   = (state == WAIT_LOCK) && bus.locked_i;
   assign dly_en    = (state == RELEASE);
   assign sw_en     = (state == SW_ASSERT);

   rst_sequencer_counter #(.TERM(LOCK_FILTER)) u_filt (
      .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .clr(!filt_en), .en(filt_en), .tc(filt_tc)
   );

   rst_sequencer_counter #(.TERM(STAGE_DELAY)) u_dly (
      .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .clr(!dly_en), .en(dly_en), .tc(dly_tc)
   );

   rst_sequencer_counter #(.TERM(SWRST_PULSE)) u_sw (
      .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .clr(!sw_en), .en(sw_en), .tc(sw_tc)
   );

   // next state: lock loss beats sw request, which beats normal sequencing
   always_comb begin
      state_d   = state;
      rst_n_d   = rst_n_q;
      idx_d     = idx;
      pending_d = pending;
      ack_d     = ack && bus.sw_rst_req_i;
      loss_d    = loss_cnt;
      if (lock_loss) begin
         state_d = WAIT_LOCK;
         rst_n_d = '0;
         loss_d  = (loss_cnt == LOSS_CNT_MAX) ? loss_cnt : loss_cnt + 8'd1;
      end else if (accept && state == RUN) begin
         state_d   = SW_ASSERT;
         rst_n_d   = '0;
         pending_d = 1'b1;
      end else begin
         pending_d = pending || accept;
         if (state == WAIT_LOCK && filt_tc) begin
            state_d = RELEASE;
            idx_d   = '0;
         end
         if (state == RELEASE && dly_tc) begin
            rst_n_d[idx] = 1'b1;
            idx_d        = idx + IW'(1);
            if (idx == IW'(NUM_DOMAINS - 1)) begin
               state_d = RUN;
               if (pending_d) begin
                  ack_d     = 1'b1;
                  pending_d = 1'b0;
               end
            end
         end
         if (state == SW_ASSERT && sw_tc)
            state_d = WAIT_LOCK;
      end
   end

   // state and registered outputs
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state    <= WAIT_LOCK;
         rst_n_q  <= '0;
         idx      <= '0;
         pending  <= 1'b0;
         ack      <= 1'b0;
         loss_cnt <= '0;
         busy_q   <= 1'b1;
         all_q    <= 1'b0;
      end else begin
         state    <= state_d;
         rst_n_q  <= rst_n_d;
         idx      <= idx_d;
         pending  <= pending_d;
         ack      <= ack_d;
         loss_cnt <= loss_d;
         busy_q   <= (state_d != RUN);
         all_q    <= (state_d == RUN);
      end
   end

   assign bus.rst_n_o         = rst_n_q;
   assign bus.sw_rst_ack_o    = ack;
   assign bus.seq_busy_o      = busy_q;
   assign bus.all_released_o  = all_q;
   assign bus.lock_loss_cnt_o = loss_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed vectors and hand-built sequences for the reset sequencer
module tb_rst_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   rst_sequencer_if #(.NUM_DOMAINS(4)) bus ();

   rst_sequencer #(
      .NUM_DOMAINS(4), .STAGE_DELAY(16), .LOCK_FILTER(8), .SWRST_PULSE(32)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_n_i(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic       locked;
      logic [3:0] rst;
      logic       busy;
      logic       all_rel;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_to(input int e);
      while (cyc < e) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.locked_i = 1'b1;
      bus.sw_rst_req_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      bus.locked_i = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      vecs[0] = '{0,  1'b1, 4'h0, 1'b1, 1'b0};
      vecs[1] = '{7,  1'b1, 4'h0, 1'b1, 1'b0};
      vecs[2] = '{8,  1'b1, 4'h0, 1'b1, 1'b0};
      vecs[3] = '{23, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[4] = '{24, 1'b1, 4'h1, 1'b1, 1'b0};
      vecs[5] = '{39, 1'b1, 4'h1, 1'b1, 1'b0};
      vecs[6] = '{40, 1'b1, 4'h3, 1'b1, 1'b0};
      vecs[7] = '{56, 1'b1, 4'h7, 1'b1, 1'b0};
      vecs[8] = '{71, 1'b1, 4'h7, 1'b1, 1'b0};
      vecs[9] = '{72, 1'b1, 4'hF, 1'b0, 1'b1};

      // scenario 1: constant lock, staggered release
      do_reset();
      chk("reset_ack", bus.sw_rst_ack_o, 0);
      chk("reset_cnt", bus.lock_loss_cnt_o, 0);
      for (int i = 0; i < 10; i++) begin
         bus.locked_i = vecs[i].locked;
         run_to(vecs[i].edge_n);
         chk($sformatf("v%0d_rst", i), bus.rst_n_o, vecs[i].rst);
         chk($sformatf("v%0d_busy", i), bus.seq_busy_o, vecs[i].busy);
         chk($sformatf("v%0d_all", i), bus.all_released_o, vecs[i].all_rel);
      end

      // scenario 3: lock loss in RUN
      run_to(80);
      bus.locked_i = 1'b0;
      run_to(81);
      chk("loss_rst", bus.rst_n_o, 4'h0);
      chk("loss_cnt", bus.lock_loss_cnt_o, 1);
      chk("loss_busy", bus.seq_busy_o, 1);
      chk("loss_all", bus.all_released_o, 0);
      bus.locked_i = 1'b1;
      run_to(152);
      chk("reseq_rst_152", bus.rst_n_o, 4'h7);
      run_to(153);
      chk("reseq_rst_153", bus.rst_n_o, 4'hF);
      chk("reseq_all_153", bus.all_released_o, 1);

      // scenario 4: software reset from RUN
      run_to(160);
      bus.sw_rst_req_i = 1'b1;
      run_to(161);
      chk("sw_rst_assert", bus.rst_n_o, 4'h0);
      chk("sw_busy", bus.seq_busy_o, 1);
      run_to(193);
      chk("sw_hold", bus.rst_n_o, 4'h0);
      run_to(264);
      chk("sw_all_264", bus.all_released_o, 0);
      chk("sw_ack_264", bus.sw_rst_ack_o, 0);
      run_to(265);
      chk("sw_all_265", bus.all_released_o, 1);
      chk("sw_ack_265", bus.sw_rst_ack_o, 1);
      chk("sw_rst_265", bus.rst_n_o, 4'hF);
      run_to(270);
      chk("sw_ack_held", bus.sw_rst_ack_o, 1);
      chk("sw_no_retrig", bus.rst_n_o, 4'hF);
      bus.sw_rst_req_i = 1'b0;
      run_to(271);
      chk("sw_ack_drop", bus.sw_rst_ack_o, 0);
      run_to(275);
      chk("sw_run_stay", bus.rst_n_o, 4'hF);
      chk("sw_cnt_same", bus.lock_loss_cnt_o, 1);

      // scenario 2: lock glitch during filtering
      do_reset();
      run_to(5);
      bus.locked_i = 1'b0;
      run_to(6);
      chk("glitch_not_counted", bus.lock_loss_cnt_o, 0);
      bus.locked_i = 1'b1;
      run_to(29);
      chk("glitch_rst_29", bus.rst_n_o, 4'h0);
      run_to(30);
      chk("glitch_rst_30", bus.rst_n_o, 4'h1);

      // scenario 5: lock loss in RELEASE with a pending sw request
      do_reset();
      run_to(29);
      bus.sw_rst_req_i = 1'b1;
      run_to(44);
      chk("pend_rst_44", bus.rst_n_o, 4'h3);
      chk("pend_ack_44", bus.sw_rst_ack_o, 0);
      bus.locked_i = 1'b0;
      run_to(45);
      chk("pend_rst_45", bus.rst_n_o, 4'h0);
      chk("pend_cnt_45", bus.lock_loss_cnt_o, 1);
      bus.locked_i = 1'b1;
      run_to(116);
      chk("pend_all_116", bus.all_released_o, 0);
      chk("pend_ack_116", bus.sw_rst_ack_o, 0);
      run_to(117);
      chk("pend_all_117", bus.all_released_o, 1);
      chk("pend_ack_117", bus.sw_rst_ack_o, 1);
      chk("pend_rst_117", bus.rst_n_o, 4'hF);
      bus.sw_rst_req_i = 1'b0;
      run_to(118);
      chk("pend_ack_118", bus.sw_rst_ack_o, 0);
      chk("pend_rst_118", bus.rst_n_o, 4'hF);

      // scenario 6: loss counter saturation, then reset mid-RELEASE
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         bus.locked_i = 1'b1;
         run_to(cyc + 8);
         bus.locked_i = 1'b0;
         run_to(cyc + 1);
         if (i == 254 || i == 255 || i == 300)
            chk($sformatf("sat_cnt_%0d", i), bus.lock_loss_cnt_o, (i > 255) ? 255 : i);
      end
      bus.locked_i = 1'b1;
      bus.sw_rst_req_i = 1'b1;
      run_to(cyc + 28);
      chk("mid_rel_rst", bus.rst_n_o, 4'h1);
      chk("mid_rel_cnt", bus.lock_loss_cnt_o, 255);
      rst_n = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      tick();
      chk("rst_mid_rst", bus.rst_n_o, 4'h0);
      chk("rst_mid_busy", bus.seq_busy_o, 1);
      chk("rst_mid_all", bus.all_released_o, 0);
      chk("rst_mid_ack", bus.sw_rst_ack_o, 0);
      chk("rst_mid_cnt", bus.lock_loss_cnt_o, 0);
      rst_n = 1'b1;
      cyc = 0;
      run_to(23);
      chk("after_rst_23", bus.rst_n_o, 4'h0);
      run_to(24);
      chk("after_rst_24", bus.rst_n_o, 4'h1);
      run_to(72);
      chk("after_rst_ack", bus.sw_rst_ack_o, 0);
      chk("after_rst_all", bus.all_released_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
